// File: rtl/text_console_ctrl.sv
// Byte-stream text terminal sequencer for port A of char_buffer.
// Tracks a cursor over a COLS x ROWS grid, writes glyphs, and performs
// clear-screen and one-row hardware scroll through the single CPU-side port.
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  output logic        buf_en,
  input  logic [7:0]  buf_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [11:0] COLS_A    = 12'(COLS);
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LAST_DST  = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] CLR_BASE  = 12'((ROWS - 1) * COLS);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CLS} state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic [11:0] dst_q, dst_d;
  logic        bs_q, bs_d;
  logic        start_scroll;

  function automatic logic [11:0] lin(input logic [4:0] r, input logic [6:0] c);
    return 12'(r) * COLS_A + 12'(c);
  endfunction

  // State, cursor and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      dst_q   <= '0;
      bs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      dst_q   <= dst_d;
      bs_q    <= bs_d;
    end
  end

  // Next-state, cursor update and next bus cycle
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    en_d         = 1'b0;
    busy_d       = 1'b0;
    dst_d        = dst_q;
    bs_d         = bs_q;
    start_scroll = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            state_d = PUT;
            addr_d  = lin(row_q, col_q);
            wdata_d = in_data;
            we_d    = 1'b1;
            en_d    = 1'b1;
            bs_d    = 1'b0;
          end else begin
            case (in_data)
              8'h08: begin
                if (col_q != '0) begin
                  state_d = PUT;
                  addr_d  = lin(row_q, col_q - 7'd1);
                  wdata_d = BLANK;
                  we_d    = 1'b1;
                  en_d    = 1'b1;
                  bs_d    = 1'b1;
                end
              end
              8'h0A: begin
                col_d = '0;
                if (row_q == LAST_ROW) start_scroll = 1'b1;
                else                   row_d = row_q + 5'd1;
              end
              8'h0D: col_d = '0;
              8'h0C: begin
                state_d = CLS;
                addr_d  = '0;
                wdata_d = BLANK;
                we_d    = 1'b1;
                en_d    = 1'b1;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        state_d = IDLE;
        if (bs_q) begin
          col_d = col_q - 7'd1;
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q == LAST_ROW) start_scroll = 1'b1;
          else                   row_d = row_q + 5'd1;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      SCR_RD: begin
        state_d = SCR_WR;
        addr_d  = dst_q;
        we_d    = 1'b1;
        en_d    = 1'b1;
        busy_d  = 1'b1;
      end
      SCR_WR: begin
        busy_d = 1'b1;
        if (dst_q == LAST_DST) begin
          state_d = SCR_CLR;
          addr_d  = CLR_BASE;
          wdata_d = BLANK;
          we_d    = 1'b1;
          en_d    = 1'b1;
        end else begin
          state_d = SCR_RD;
          dst_d   = dst_q + 12'd1;
          addr_d  = dst_q + 12'd1 + COLS_A;
          en_d    = 1'b1;
        end
      end
      SCR_CLR, CLS: begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          if (state_q == CLS) begin
            row_d = '0;
            col_d = '0;
          end
        end else begin
          addr_d  = addr_q + 12'd1;
          wdata_d = BLANK;
          we_d    = 1'b1;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_scroll) begin
      state_d = SCR_RD;
      addr_d  = COLS_A;
      en_d    = 1'b1;
      busy_d  = 1'b1;
      dst_d   = '0;
    end
  end

  assign in_ready   = (state_q == IDLE);
  // Read data only arrives during the write cycle itself, so the scroll
  // copy passes it straight through instead of waiting a further cycle.
  assign buf_wdata  = (state_q == SCR_WR) ? buf_rdata : wdata_q;
  assign buf_addr   = addr_q;
  assign buf_we     = we_q;
  assign buf_en     = en_q;
  assign busy       = busy_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl with a behavioural char_buffer port A.
module tb_text_console_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic        buf_we;
  logic        buf_en;
  logic [7:0]  buf_rdata;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;
  logic        preload;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  exp_mem [0:4095];
  logic [19:0] wq [$];
  int          mrow, mcol;

  text_console_ctrl #(.COLS(80), .ROWS(30), .BLANK(8'h20)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .buf_we(buf_we), .buf_en(buf_en), .buf_rdata(buf_rdata),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  // char_buffer port A: synchronous write, registered read-first output
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 80; i < 160; i++) mem[i] <= 8'h31;
    end else begin
      if (buf_we) mem[buf_addr] <= buf_wdata;
      if (buf_en) buf_rdata <= mem[buf_addr];
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every observed write strobe must match the next expected write
  always @(negedge clk) begin
    if (buf_we) begin
      chk("wr_expected", (wq.size() > 0) ? 1 : 0, 1);
      chk("wr_en", int'(buf_en), 1);
      if (wq.size() > 0) begin
        logic [19:0] e;
        e = wq.pop_front();
        chk("wr_addr", int'(buf_addr), int'(e[19:8]));
        chk("wr_data", int'(buf_wdata), int'(e[7:0]));
      end
    end
  end

  task automatic push(input int a, input logic [7:0] d);
    wq.push_back({12'(a), d});
    exp_mem[a] = d;
  endtask

  task automatic model_scroll();
    for (int d = 0; d < 29 * 80; d++) push(d, exp_mem[d + 80]);
    for (int d = 29 * 80; d < 30 * 80; d++) push(d, 8'h20);
  endtask

  task automatic model_newline();
    mcol = 0;
    if (mrow == 29) model_scroll();
    else mrow++;
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(mrow * 80 + mcol, c);
      if (mcol == 79) model_newline();
      else mcol++;
    end else if (c == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push(mrow * 80 + mcol, 8'h20);
      end
    end else if (c == 8'h0A) begin
      model_newline();
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h0C) begin
      for (int a = 0; a < 2400; a++) push(a, 8'h20);
      mrow = 0;
      mcol = 0;
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    for (int i = 0; i < 10000 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n, output int nb);
    n  = 0;
    nb = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (in_ready) break;
      n++;
    end
    chk("idle_reached", int'(in_ready), 1);
  endtask

  task automatic put(input logic [7:0] c, input int exp_n, output int nb);
    int n;
    model_char(c);
    send(c);
    wait_idle(n, nb);
    if (exp_n >= 0) chk("latency", n, exp_n);
    chk("cursor_row", int'(cursor_row), mrow);
    chk("cursor_col", int'(cursor_col), mcol);
  endtask

  initial begin
    int n, nb, sum;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; preload = 1'b0;
    mrow = 0; mcol = 0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_row", int'(cursor_row), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_addr", int'(buf_addr), 0);
    chk("rst_wdata", int'(buf_wdata), 0);
    chk("rst_we", int'(buf_we), 0);
    chk("rst_en", int'(buf_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 1);

    put(8'h41, 1, nb);
    put(8'h42, 1, nb);
    chk("ab_col", int'(cursor_col), 2);

    // Clear screen: 2400 blank writes with in_ready low all the way
    model_char(8'h0C);
    send(8'h0C);
    wait_idle(n, nb);
    chk("cls_ready_low", n, 2400);
    chk("cls_busy", nb, 2400);
    chk("cls_row", int'(cursor_row), 0);
    chk("cls_col", int'(cursor_col), 0);
    chk("cls_drained", wq.size(), 0);

    // One full row wraps to the next row without scrolling
    sum = 0;
    for (int i = 0; i < 80; i++) begin
      put(8'(8'h21 + (i % 90)), 1, nb);
      sum += nb;
    end
    chk("wrap_row", int'(cursor_row), 1);
    chk("wrap_col", int'(cursor_col), 0);
    chk("wrap_no_busy", sum, 0);

    put(8'h61, 1, nb);
    put(8'h62, 1, nb);
    put(8'h0D, 0, nb);
    put(8'h01, 0, nb);
    put(8'h0A, 0, nb);
    put(8'h0A, 0, nb);
    chk("bs0_row", int'(cursor_row), 3);
    put(8'h08, -1, nb);
    chk("bs0_col", int'(cursor_col), 0);
    for (int i = 0; i < 4; i++) put(8'(8'h61 + i), 1, nb);
    put(8'h08, 1, nb);
    chk("bs_col", int'(cursor_col), 3);
    chk("bs_mem", int'(mem[243]), 8'h20);

    // Move to the last row, leave a marker, preload row 1, then scroll
    for (int i = 0; i < 26; i++) put(8'h0A, 0, nb);
    for (int i = 0; i < 5; i++) put(8'h78, 1, nb);
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 80; i < 160; i++) exp_mem[i] = 8'h31;
    put(8'h0A, -1, nb);
    chk("scroll_busy", nb, 4720);
    chk("scroll_mem0", int'(mem[0]), 8'h31);
    chk("scroll_mem79", int'(mem[79]), 8'h31);
    chk("scroll_row28", int'(mem[2240]), 8'h78);
    sum = 0;
    for (int a = 2320; a < 2400; a++) if (mem[a] != 8'h20) sum++;
    chk("scroll_lastrow_blank", sum, 0);
    chk("scroll_drained", wq.size(), 0);

    // Reset 100 cycles into a scroll
    model_char(8'h0A);
    send(8'h0A);
    repeat (100) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_row", int'(cursor_row), 29);
    chk("mid_col", int'(cursor_col), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    wq.delete();
    mrow = 0;
    mcol = 0;
    chk("mrst_we", int'(buf_we), 0);
    chk("mrst_row", int'(cursor_row), 0);
    chk("mrst_col", int'(cursor_col), 0);
    chk("mrst_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    put(8'h5A, 1, nb);
    repeat (3) @(negedge clk);
    chk("z_mem", int'(mem[0]), 8'h5A);
    chk("final_drained", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
